// File: rtl/bitcnt_pkg.sv
// Shared encodings and constants for the bit-count frame accumulator.
package bitcnt_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_e;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] MAX_CNT = 4'd8;

    // A byte popcount can never exceed the byte width.
    function automatic logic cnt_illegal(input logic [CNT_W-1:0] cnt);
        return (cnt > MAX_CNT);
    endfunction

endpackage

// File: rtl/bitcnt_frame_accum.sv
// Sums per-byte popcounts into frame totals and presents them on a valid/ack
// handshake with a one-entry result buffer. Optional BITCNT_MAX_EN adds o_max_cnt.
module bitcnt_frame_accum
    import bitcnt_pkg::*;
#(
    parameter int FRAME_LEN = 4,
    parameter int SUM_W     = 6,
    parameter int IDX_W     = 8
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              i_cnt_valid,
    input  logic [CNT_W-1:0]  i_bit_cnt,
    input  logic              i_flush,
    input  logic              i_frame_ack,
    output logic [SUM_W-1:0]  o_sum,
    output logic [IDX_W-1:0]  o_nbytes,
    output logic              o_frame_valid,
    output logic              o_ovf,
`ifdef BITCNT_MAX_EN
    output logic [CNT_W-1:0]  o_max_cnt,
`endif
    output logic              o_err
);

    state_e             state_r;
    logic [SUM_W-1:0]   acc_r;
    logic [IDX_W-1:0]   idx_r;
    logic [SUM_W-1:0]   sum_r;
    logic [IDX_W-1:0]   nbytes_r;
    logic               valid_r;
    logic               ovf_r;
    logic               err_r;

    logic [SUM_W-1:0]   acc_final_s;
    logic [IDX_W-1:0]   idx_final_s;
    logic               close_s;
    logic               ack_s;
    logic               load_s;
    logic               drop_s;

`ifdef BITCNT_MAX_EN
    logic [CNT_W-1:0]   fmax_r;
    logic [CNT_W-1:0]   max_out_r;
    logic [CNT_W-1:0]   fmax_final_s;
`endif

    // Post-add view of the frame and the close/load/drop decisions
    always_comb begin
        acc_final_s = acc_r;
        idx_final_s = idx_r;
        if (i_cnt_valid) begin
            acc_final_s = acc_r + SUM_W'(i_bit_cnt);
            idx_final_s = idx_r + IDX_W'(1);
        end else begin
            acc_final_s = acc_r;
            idx_final_s = idx_r;
        end
        // A flush only closes a frame that holds at least one byte after this cycle.
        close_s = (i_cnt_valid && (idx_final_s == IDX_W'(FRAME_LEN)))
               || (i_flush && (i_cnt_valid || (state_r == S_ACCUM)));
        ack_s   = i_frame_ack && valid_r;
        load_s  = close_s && (!valid_r || ack_s);
        drop_s  = close_s && valid_r && !ack_s;
    end

`ifdef BITCNT_MAX_EN
    // Running per-frame maximum including the byte arriving this cycle
    always_comb begin
        fmax_final_s = fmax_r;
        if (i_cnt_valid && (i_bit_cnt > fmax_r)) begin
            fmax_final_s = i_bit_cnt;
        end else begin
            fmax_final_s = fmax_r;
        end
    end
`endif

    // Frame FSM, accumulator, result buffer and sticky flags
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_r  <= S_IDLE;
            acc_r    <= {SUM_W{1'b0}};
            idx_r    <= {IDX_W{1'b0}};
            sum_r    <= {SUM_W{1'b0}};
            nbytes_r <= {IDX_W{1'b0}};
            valid_r  <= 1'b0;
            ovf_r    <= 1'b0;
            err_r    <= 1'b0;
`ifdef BITCNT_MAX_EN
            fmax_r    <= {CNT_W{1'b0}};
            max_out_r <= {CNT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (i_cnt_valid && !close_s) begin
                        state_r <= S_ACCUM;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ACCUM: begin
                    if (close_s) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_ACCUM;
                    end
                end
                default: state_r <= S_IDLE;
            endcase

            if (close_s) begin
                acc_r <= {SUM_W{1'b0}};
                idx_r <= {IDX_W{1'b0}};
            end else begin
                acc_r <= acc_final_s;
                idx_r <= idx_final_s;
            end

            if (load_s) begin
                sum_r    <= acc_final_s;
                nbytes_r <= idx_final_s;
                valid_r  <= 1'b1;
            end else if (ack_s) begin
                valid_r  <= 1'b0;
            end else begin
                valid_r  <= valid_r;
            end

            if (drop_s) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end

            if (i_cnt_valid && cnt_illegal(i_bit_cnt)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end

`ifdef BITCNT_MAX_EN
            if (close_s) begin
                fmax_r <= {CNT_W{1'b0}};
            end else begin
                fmax_r <= fmax_final_s;
            end
            if (load_s) begin
                max_out_r <= fmax_final_s;
            end else begin
                max_out_r <= max_out_r;
            end
`endif
        end
    end

    assign o_sum         = sum_r;
    assign o_nbytes      = nbytes_r;
    assign o_frame_valid = valid_r;
    assign o_ovf         = ovf_r;
    assign o_err         = err_r;
`ifdef BITCNT_MAX_EN
    assign o_max_cnt     = max_out_r;
`endif

endmodule

// File: tb/tb_bitcnt_frame_accum.sv
// Directed self-checking bench for bitcnt_frame_accum (FRAME_LEN=4, SUM_W=6).
module tb_bitcnt_frame_accum;

    logic       iclk = 1'b0;
    logic       irst = 1'b0;
    logic       i_cnt_valid = 1'b0;
    logic [3:0] i_bit_cnt = 4'd0;
    logic       i_flush = 1'b0;
    logic       i_frame_ack = 1'b0;
    logic [5:0] o_sum;
    logic [7:0] o_nbytes;
    logic       o_frame_valid;
    logic       o_ovf;
    logic       o_err;
`ifdef BITCNT_MAX_EN
    logic [3:0] o_max_cnt;
`endif

    int tests = 0;
    int fails = 0;

    bitcnt_frame_accum #(.FRAME_LEN(4), .SUM_W(6), .IDX_W(8)) dut (
        .iclk          (iclk),
        .irst          (irst),
        .i_cnt_valid   (i_cnt_valid),
        .i_bit_cnt     (i_bit_cnt),
        .i_flush       (i_flush),
        .i_frame_ack   (i_frame_ack),
        .o_sum         (o_sum),
        .o_nbytes      (o_nbytes),
        .o_frame_valid (o_frame_valid),
        .o_ovf         (o_ovf),
`ifdef BITCNT_MAX_EN
        .o_max_cnt     (o_max_cnt),
`endif
        .o_err         (o_err)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [3:0] c, input logic f, input logic a);
        i_cnt_valid = v;
        i_bit_cnt   = c;
        i_flush     = f;
        i_frame_ack = a;
        @(posedge iclk);
        #1;
        i_cnt_valid = 1'b0;
        i_bit_cnt   = 4'd0;
        i_flush     = 1'b0;
        i_frame_ack = 1'b0;
    endtask

    task automatic do_reset();
        irst = 1'b1;
        cyc(1'b0, 4'd0, 1'b0, 1'b0);
        irst = 1'b0;
    endtask

    initial begin
        // 1. reset held with valids: nothing accumulates
        irst = 1'b1;
        cyc(1'b1, 4'd8, 1'b0, 1'b0);
        cyc(1'b1, 4'd8, 1'b0, 1'b0);
        chk("rst_sum", o_sum, 0);
        chk("rst_nbytes", o_nbytes, 0);
        chk("rst_valid", o_frame_valid, 0);
        chk("rst_ovf", o_ovf, 0);
        chk("rst_err", o_err, 0);
        irst = 1'b0;
        cyc(1'b0, 4'd0, 1'b1, 1'b0);
        chk("rst_no_frame", o_frame_valid, 0);

        // 2. full frame 6,6,4,4
        cyc(1'b1, 4'd6, 1'b0, 1'b0);
        cyc(1'b1, 4'd6, 1'b0, 1'b0);
        cyc(1'b1, 4'd4, 1'b0, 1'b0);
        chk("full_pre_valid", o_frame_valid, 0);
        cyc(1'b1, 4'd4, 1'b0, 1'b0);
        chk("full_sum", o_sum, 20);
        chk("full_nbytes", o_nbytes, 4);
        chk("full_valid", o_frame_valid, 1);
        cyc(1'b0, 4'd0, 1'b0, 1'b0);
        chk("full_hold", o_frame_valid, 1);
        cyc(1'b0, 4'd0, 1'b0, 1'b1);
        chk("full_acked", o_frame_valid, 0);
        chk("full_sum_kept", o_sum, 20);

        // 3. partial frame closed by flush, then empty flush
        cyc(1'b1, 4'd3, 1'b0, 1'b0);
        cyc(1'b1, 4'd5, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 1'b1, 1'b0);
        chk("flush_sum", o_sum, 8);
        chk("flush_nbytes", o_nbytes, 2);
        chk("flush_valid", o_frame_valid, 1);
        cyc(1'b0, 4'd0, 1'b0, 1'b1);
        cyc(1'b0, 4'd0, 1'b1, 1'b0);
        chk("empty_flush", o_frame_valid, 0);
        cyc(1'b0, 4'd0, 1'b0, 1'b1);
        chk("ack_idle_ignored", o_frame_valid, 0);

        // valid and flush together: byte included
        cyc(1'b1, 4'd1, 1'b0, 1'b0);
        cyc(1'b1, 4'd2, 1'b1, 1'b0);
        chk("vflush_sum", o_sum, 3);
        chk("vflush_nbytes", o_nbytes, 2);
        cyc(1'b0, 4'd0, 1'b0, 1'b1);

        // 4a. overflow: A unacked, B of four 8s dropped
        cyc(1'b1, 4'd3, 1'b0, 1'b0);
        cyc(1'b1, 4'd5, 1'b1, 1'b0);
        chk("ovfA_sum", o_sum, 8);
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'd8, 1'b0, 1'b0);
        chk("ovf_set", o_ovf, 1);
        chk("ovf_sum_kept", o_sum, 8);
        chk("ovf_nbytes_kept", o_nbytes, 2);
        chk("ovf_valid", o_frame_valid, 1);
        cyc(1'b0, 4'd0, 1'b0, 1'b1);
        chk("ovf_sticky", o_ovf, 1);
        do_reset();
        chk("ovf_cleared", o_ovf, 0);

        // 4b. back-to-back: ack on B's closing cycle
        cyc(1'b1, 4'd3, 1'b0, 1'b0);
        cyc(1'b1, 4'd5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'd8, 1'b0, 1'b0);
        chk("b2b_A_held", o_sum, 8);
        cyc(1'b1, 4'd8, 1'b0, 1'b1);
        chk("b2b_sum", o_sum, 32);
        chk("b2b_nbytes", o_nbytes, 4);
        chk("b2b_valid", o_frame_valid, 1);
        chk("b2b_ovf", o_ovf, 0);
        cyc(1'b0, 4'd0, 1'b0, 1'b1);
        chk("b2b_acked", o_frame_valid, 0);

        // 5. illegal count 15 sets sticky error, still summed
        cyc(1'b1, 4'hF, 1'b0, 1'b0);
        chk("err_set", o_err, 1);
        cyc(1'b1, 4'd1, 1'b1, 1'b0);
        chk("err_sum", o_sum, 16);
        chk("err_nbytes", o_nbytes, 2);
        cyc(1'b0, 4'd0, 1'b0, 1'b1);
        chk("err_sticky", o_err, 1);
        do_reset();
        chk("err_cleared", o_err, 0);

`ifdef BITCNT_MAX_EN
        // 6a. frame maximum
        cyc(1'b1, 4'd2, 1'b0, 1'b0);
        cyc(1'b1, 4'd7, 1'b0, 1'b0);
        cyc(1'b1, 4'd1, 1'b0, 1'b0);
        cyc(1'b1, 4'd0, 1'b0, 1'b0);
        chk("max_sum", o_sum, 10);
        chk("max_cnt", o_max_cnt, 7);
        cyc(1'b0, 4'd0, 1'b0, 1'b1);
`endif

        // 6b. reset mid-frame: next frame starts from zero
        cyc(1'b1, 4'd5, 1'b0, 1'b0);
        cyc(1'b1, 4'd5, 1'b0, 1'b0);
        do_reset();
`ifdef BITCNT_MAX_EN
        chk("midrst_max", o_max_cnt, 0);
`endif
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'd1, 1'b0, 1'b0);
        chk("midrst_no_early", o_frame_valid, 0);
        cyc(1'b1, 4'd1, 1'b0, 1'b0);
        chk("midrst_sum", o_sum, 4);
        chk("midrst_nbytes", o_nbytes, 4);
        chk("midrst_valid", o_frame_valid, 1);
`ifdef BITCNT_MAX_EN
        chk("midrst_max_after", o_max_cnt, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
